// File: rtl/waterfall_ctrl.sv
// Circular line-buffer controller for a waterfall display built on one dual-port bram.
// Latency: a write reaches the bram in the same cycle it is accepted; read data returns 1 cycle after rd_req.
// Backpressure: s_ready drops only while hold is high; display reads are never stalled (one per cycle).
//
// Ports:
//   clk, reset_n           single clock, asynchronous active-low reset
//   s_data/s_valid/s_ready sample stream in; hold pauses ingestion (scroll freeze)
//   frame_start            freezes the head/fill snapshot used by the read side
//   rd_req/rd_row/rd_col   display request, rd_row 0 = newest completed line
//   rd_valid/rd_data       read response, zero for lines that do not exist yet
//   bram_*                 write and read ports of the external dual-port bram
//   head_row, rows_filled  write-side status; line_done pulses after each completed line
module waterfall_ctrl #(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 5,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   hold,
  input  logic                   frame_start,
  input  logic                   rd_req,
  input  logic [ROW_W-1:0]       rd_row,
  input  logic [COL_W-1:0]       rd_col,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [ROW_W+COL_W-1:0] bram_w_addr,
  output logic                   bram_w_en,
  output logic [DATA_W-1:0]      bram_d_in,
  output logic [ROW_W+COL_W-1:0] bram_r_addr,
  output logic                   bram_r_en,
  input  logic [DATA_W-1:0]      bram_d_out,
  output logic [ROW_W-1:0]       head_row,
  output logic [ROW_W:0]         rows_filled,
  output logic                   line_done
);

  // rows_filled saturates at ROWS, which needs the extra top bit.
  localparam logic [ROW_W:0] ROWS_FULL = {1'b1, {ROW_W{1'b0}}};

  logic [ROW_W-1:0] head_row_q, head_row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W:0]   rows_filled_q, rows_filled_d;
  logic [ROW_W-1:0] frame_head_q, frame_head_d;
  logic [ROW_W:0]   frame_filled_q, frame_filled_d;
  logic             rd_valid_q;
  logic             line_done_q;
  logic             blank_q, blank_d;

  logic             accept;
  logic             line_end;
  logic [ROW_W-1:0] phys_row;

  // ---------------- write side ----------------
  assign s_ready  = !hold;
  assign accept   = s_valid && s_ready;
  assign line_end = accept && (&col_q);

  assign bram_w_en   = accept;
  assign bram_w_addr = {head_row_q, col_q};
  assign bram_d_in   = s_data;

  always_comb begin
    col_d         = col_q;
    head_row_d    = head_row_q;
    rows_filled_d = rows_filled_q;
    if (accept) begin
      if (line_end) begin
        col_d      = '0;
        head_row_d = head_row_q + ROW_W'(1);
        if (rows_filled_q != ROWS_FULL) begin
          rows_filled_d = rows_filled_q + (ROW_W+1)'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // ---------------- frame snapshot ----------------
  // Snapshot takes the current register values, so a line finishing on the
  // same edge as frame_start is only visible from the following frame.
  always_comb begin
    frame_head_d   = frame_head_q;
    frame_filled_d = frame_filled_q;
    if (frame_start) begin
      frame_head_d   = head_row_q;
      frame_filled_d = rows_filled_q;
    end
  end

  // ---------------- read side ----------------
  // Newest completed line sits one row behind the frozen head; modular
  // subtraction in ROW_W bits gives the wrap for free.
  assign phys_row    = frame_head_q - ROW_W'(1) - rd_row;
  assign bram_r_addr = {phys_row, rd_col};
  assign bram_r_en   = rd_req;

  // Rows beyond what had been filled at the snapshot read as zero, which also
  // hides stale bram contents left over from before a reset.
  always_comb begin
    blank_d = blank_q;
    if (rd_req) begin
      blank_d = ({1'b0, rd_row} >= frame_filled_q);
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = (rd_valid_q && !blank_q) ? bram_d_out : '0;

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_row_q     <= '0;
      col_q          <= '0;
      rows_filled_q  <= '0;
      frame_head_q   <= '0;
      frame_filled_q <= '0;
      rd_valid_q     <= 1'b0;
      line_done_q    <= 1'b0;
      blank_q        <= 1'b1;
    end else begin
      head_row_q     <= head_row_d;
      col_q          <= col_d;
      rows_filled_q  <= rows_filled_d;
      frame_head_q   <= frame_head_d;
      frame_filled_q <= frame_filled_d;
      rd_valid_q     <= rd_req;
      line_done_q    <= line_end;
      blank_q        <= blank_d;
    end
  end

  assign head_row    = head_row_q;
  assign rows_filled = rows_filled_q;
  assign line_done   = line_done_q;

endmodule

// File: tb/tb_waterfall_ctrl.sv
// Bench for waterfall_ctrl with 4 lines x 4 columns and a behavioural bram.
// Latency: read responses are scored one cycle after their request.
// Backpressure: hold is driven with s_valid high to exercise the stall path.
module tb_waterfall_ctrl;

  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [DATA_W-1:0]      s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   hold;
  logic                   frame_start;
  logic                   rd_req;
  logic [ROW_W-1:0]       rd_row;
  logic [COL_W-1:0]       rd_col;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic [ROW_W+COL_W-1:0] bram_w_addr;
  logic                   bram_w_en;
  logic [DATA_W-1:0]      bram_d_in;
  logic [ROW_W+COL_W-1:0] bram_r_addr;
  logic                   bram_r_en;
  logic [DATA_W-1:0]      bram_d_out;
  logic [ROW_W-1:0]       head_row;
  logic [ROW_W:0]         rows_filled;
  logic                   line_done;

  waterfall_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .hold(hold), .frame_start(frame_start),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .bram_w_addr(bram_w_addr), .bram_w_en(bram_w_en), .bram_d_in(bram_d_in),
    .bram_r_addr(bram_r_addr), .bram_r_en(bram_r_en), .bram_d_out(bram_d_out),
    .head_row(head_row), .rows_filled(rows_filled), .line_done(line_done)
  );

  always #5 clk = ~clk;

  // Dual-port bram with registered read.
  logic [DATA_W-1:0] mem [16];
  always @(posedge clk) begin
    if (bram_w_en) mem[bram_w_addr] <= bram_d_in;
    if (bram_r_en) bram_d_out <= mem[bram_r_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Read scoreboard: expected data and issue cycle.
  typedef struct {
    int exp;
    int cyc;
  } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin
    sb_t e;
    if (reset_n) begin
      if (rd_valid) begin
        if (sbq.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rd_data", int'(rd_data), e.exp);
          chk("rd_latency", cyc, e.cyc + 1);
        end
      end else begin
        chk("rd_idle_zero", int'(rd_data), 0);
      end
    end
  end

  // Write-side reference state.
  int m_head, m_col, m_filled;
  int m_ld;
  int last_w_addr;

  task automatic tick(input logic v, input int d, input logic h, input logic fs,
                      input logic rq, input int row, input int col, input int rexp);
    logic acc;
    sb_t  e;
    @(negedge clk);
    chk("line_done", int'(line_done), m_ld);
    chk("head_row", int'(head_row), m_head);
    chk("rows_filled", int'(rows_filled), m_filled);
    s_valid     = v;
    s_data      = 8'(d);
    hold        = h;
    frame_start = fs;
    rd_req      = rq;
    rd_row      = 2'(row);
    rd_col      = 2'(col);
    #1;
    acc = v && !h;
    chk("s_ready", int'(s_ready), int'(!h));
    chk("w_en", int'(bram_w_en), int'(acc));
    if (acc) begin
      chk("w_addr", int'(bram_w_addr), m_head * 4 + m_col);
      chk("w_data", int'(bram_d_in), d);
      last_w_addr = int'(bram_w_addr);
    end
    chk("r_en", int'(bram_r_en), int'(rq));
    if (rq) begin
      e.exp = rexp;
      e.cyc = cyc;
      sbq.push_back(e);
    end
    m_ld = (acc && m_col == 3) ? 1 : 0;
    if (acc) begin
      if (m_col == 3) begin
        m_col  = 0;
        m_head = (m_head + 1) % 4;
        if (m_filled < 4) m_filled++;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic wr(input int d);
    tick(1'b1, d, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask
  task automatic idle();
    tick(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask
  task automatic fstart();
    tick(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask
  task automatic rd(input int row, input int col, input int exp);
    tick(1'b0, 0, 1'b0, 1'b0, 1'b1, row, col, exp);
  endtask
  task automatic wr_line(input int base);
    for (int c = 0; c < 4; c++) wr(base + c);
  endtask

  // Asserts reset immediately (mid-cycle), checks the async clear, releases on a negedge.
  task automatic do_reset();
    s_valid = 1'b0; s_data = '0; hold = 1'b0; frame_start = 1'b0;
    rd_req = 1'b0; rd_row = '0; rd_col = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_head_row", int'(head_row), 0);
    chk("rst_rows_filled", int'(rows_filled), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_line_done", int'(line_done), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    m_head = 0; m_col = 0; m_filled = 0; m_ld = 0;
    sbq.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int row;
    int col;
    int exp;
  } rd_vec_t;
  rd_vec_t wrap_vec [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // After five lines (line k = 0x10*k+col) the newest is line 4, oldest line 1.
    wrap_vec[0] = '{0, 1, 8'h41};
    wrap_vec[1] = '{1, 0, 8'h30};
    wrap_vec[2] = '{2, 2, 8'h22};
    wrap_vec[3] = '{3, 3, 8'h13};

    // 1. Reset state and a blank read.
    do_reset();
    rd(0, 0, 8'h00);
    idle();

    // 2. Single line, then frame_start and reads.
    wr_line(8'h10);
    fstart();
    rd(0, 2, 8'h12);
    rd(1, 0, 8'h00);
    idle();

    // 3. Wrap across five lines, table-driven back-to-back reads.
    do_reset();
    for (int k = 0; k < 5; k++) wr_line(8'h10 * k);
    fstart();
    chk("wrap_head_row", int'(head_row), 1);
    chk("wrap_rows_filled", int'(rows_filled), 4);
    for (int i = 0; i < 4; i++) rd(wrap_vec[i].row, wrap_vec[i].col, wrap_vec[i].exp);
    idle();

    // 4. Frame freeze while a new line is written.
    do_reset();
    wr_line(8'h00);
    wr_line(8'h10);
    fstart();
    wr_line(8'h20);
    rd(0, 0, 8'h10);
    rd(1, 0, 8'h00);
    fstart();
    rd(0, 0, 8'h20);
    // frame_start on the same edge a line completes: that line is excluded.
    wr(8'h30); wr(8'h31); wr(8'h32);
    tick(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    rd(0, 0, 8'h20);
    fstart();
    rd(0, 3, 8'h33);
    idle();

    // 5. Hold mid-line with s_valid still asserted.
    do_reset();
    wr(8'h50);
    wr(8'h51);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h5f, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    wr(8'h52);
    chk("hold_resume_addr", last_w_addr, 2);
    wr(8'h53);
    idle();
    chk("hold_line_head", int'(head_row), 1);

    // 6. Reset in the middle of line 1.
    do_reset();
    wr_line(8'h60);
    wr(8'h70); wr(8'h71); wr(8'h72);
    idle();
    do_reset();
    fstart();
    rd(0, 0, 8'h00);
    rd(1, 1, 8'h00);
    rd(3, 3, 8'h00);
    idle();
    idle();

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
